// File: rtl/frame_copy_engine_if.sv
// Bundle between the frame copy engine, both background RAM ports,
// the VGA frame trigger and the processor PIO handshake lines.
interface frame_copy_engine_if #(
    parameter int AW = 17,
    parameter int CW = 5
);
    logic          done;
    logic          TRIGGER;
    logic          swap;
    logic [AW-1:0] bb_raddr;
    logic [CW-1:0] bb_rdata;
    logic [AW-1:0] fb_waddr;
    logic [CW-1:0] fb_wdata;
    logic          fb_we;
    logic          select;
    logic          busy;

    modport master (
        input  done, TRIGGER, bb_rdata,
        output swap, bb_raddr, fb_waddr, fb_wdata, fb_we, select, busy
    );

    modport slave (
        output done, TRIGGER, bb_rdata,
        input  swap, bb_raddr, fb_waddr, fb_wdata, fb_we, select, busy
    );
endinterface

// File: rtl/frame_copy_engine.sv
// Copies the back buffer into the front buffer on the next VGA frame edge,
// then signals the processor with a four-phase swap handshake.
module frame_copy_engine #(
    parameter int NUMBER_COLORS = 9,
    parameter int WIDTH         = 320,
    parameter int HEIGHT        = 240,
    parameter int RD_LATENCY    = 1
) (
    input  logic CLOCK_50,
    input  logic resetn,
    frame_copy_engine_if.master bus
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(NUMBER_COLORS) + 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [2:0] {IDLE, WAIT_VB, COPY, FLUSH, SWAP} state_t;

    state_t        state, state_next;
    logic          trig_r;
    logic          edge_ev;
    logic [AW-1:0] cnt;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [AW-1:0] addr_pipe [RD_LATENCY];
    logic          last_write;
    logic [CW-1:0] pix;

    assign edge_ev    = trig_r & ~bus.TRIGGER;
    // The final write leaves the pipeline exactly in the last FLUSH cycle.
    assign last_write = vld_pipe[RD_LATENCY-1] && (addr_pipe[RD_LATENCY-1] == LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.done) state_next = WAIT_VB;
            WAIT_VB: begin
                if (!bus.done)    state_next = IDLE;
                else if (edge_ev) state_next = COPY;
            end
            COPY:    if (cnt == LAST) state_next = FLUSH;
            FLUSH:   if (last_write) state_next = SWAP;
            SWAP:    if (!bus.done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            trig_r <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            trig_r <= bus.TRIGGER;
            if (state == WAIT_VB && state_next == COPY)
                cnt <= '0;
            else if (state == COPY && cnt != LAST)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            for (int unsigned i = 0; i < unsigned'(RD_LATENCY); i++)
                addr_pipe[i] <= '0;
        end else begin
            vld_pipe[0]  <= (state == COPY);
            addr_pipe[0] <= cnt;
            for (int unsigned i = 1; i < unsigned'(RD_LATENCY); i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign pix          = bus.bb_rdata;
    assign bus.fb_wdata = pix;
    assign bus.fb_we    = vld_pipe[RD_LATENCY-1];
    assign bus.fb_waddr = addr_pipe[RD_LATENCY-1];
    assign bus.bb_raddr = cnt;
    assign bus.swap     = (state == SWAP);
    assign bus.select   = (state == COPY) || (state == FLUSH);
    assign bus.busy     = (state == WAIT_VB) || (state == COPY) || (state == FLUSH);
endmodule

// File: tb/tb_frame_copy_engine.sv
// Directed bench: two engines (read latency 1 and 3) on an 8-pixel frame,
// back-buffer models return data[a] = a + 3.
module tb_frame_copy_engine;
    localparam int N = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    frame_copy_engine_if #(.AW(3), .CW(5)) if1 ();
    frame_copy_engine_if #(.AW(3), .CW(5)) if3 ();

    frame_copy_engine #(.NUMBER_COLORS(9), .WIDTH(4), .HEIGHT(2), .RD_LATENCY(1)) dut1 (
        .CLOCK_50(clk), .resetn(resetn), .bus(if1.master));
    frame_copy_engine #(.NUMBER_COLORS(9), .WIDTH(4), .HEIGHT(2), .RD_LATENCY(3)) dut3 (
        .CLOCK_50(clk), .resetn(resetn), .bus(if3.master));

    logic done_v [2];
    logic trig_v [2];
    logic [4:0] rd1;
    logic [4:0] p3 [3];

    assign if1.done    = done_v[0];
    assign if1.TRIGGER = trig_v[0];
    assign if3.done    = done_v[1];
    assign if3.TRIGGER = trig_v[1];

    always @(posedge clk) begin
        rd1   <= 5'(if1.bb_raddr) + 5'd3;
        p3[0] <= 5'(if3.bb_raddr) + 5'd3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign if1.bb_rdata = rd1;
    assign if3.bb_rdata = p3[2];

    int sel = 0;
    logic o_we, o_swap, o_sel, o_busy;
    logic [2:0] o_waddr, o_raddr;
    logic [4:0] o_wdata;
    always_comb begin
        o_we    = (sel == 1) ? if3.fb_we    : if1.fb_we;
        o_swap  = (sel == 1) ? if3.swap     : if1.swap;
        o_sel   = (sel == 1) ? if3.select   : if1.select;
        o_busy  = (sel == 1) ? if3.busy     : if1.busy;
        o_waddr = (sel == 1) ? if3.fb_waddr : if1.fb_waddr;
        o_raddr = (sel == 1) ? if3.bb_raddr : if1.bb_raddr;
        o_wdata = (sel == 1) ? if3.fb_wdata : if1.fb_wdata;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge right after the clock that enters COPY.
    task automatic start_copy(input int s);
        done_v[s] = 1'b1;
        trig_v[s] = 1'b1;
        tick();
        trig_v[s] = 1'b0;
        tick();
    endtask

    task automatic run_copy(input int s, input int lat, input bit disturb, input int hold);
        int writes;
        bit exp_we, exp_swap, exp_busy;
        writes = 0;
        chk("copy_start_busy", 32'(o_busy), 1);
        chk("copy_start_select", 32'(o_sel), 1);
        chk("copy_start_we", 32'(o_we), 0);
        chk("copy_start_raddr", 32'(o_raddr), 0);
        for (int cyc = 1; cyc <= N + lat + hold; cyc++) begin
            if (disturb && cyc == lat + 3) trig_v[s] = 1'b1;
            if (disturb && cyc == lat + 4) begin
                trig_v[s] = 1'b0;
                done_v[s] = 1'b0;
            end
            tick();
            exp_we   = (cyc >= lat) && (cyc < lat + N);
            exp_swap = disturb ? (cyc == N + lat) : (cyc >= N + lat);
            exp_busy = (cyc < N + lat);
            chk("copy_we", 32'(o_we), 32'(exp_we));
            chk("copy_swap", 32'(o_swap), 32'(exp_swap));
            chk("copy_busy", 32'(o_busy), 32'(exp_busy));
            chk("copy_select", 32'(o_sel), 32'(exp_busy));
            if (o_we) writes++;
            if (exp_we) begin
                chk("copy_waddr", 32'(o_waddr), 32'(cyc - lat));
                chk("copy_wdata", 32'(o_wdata), 32'(cyc - lat + 3));
            end
        end
        chk("copy_write_count", 32'(writes), 32'(N));
        chk("copy_raddr_hold", 32'(o_raddr), 32'(N - 1));
        if (!disturb) begin
            done_v[s] = 1'b0;
            tick();
            chk("release_swap", 32'(o_swap), 0);
            chk("release_select", 32'(o_sel), 0);
            chk("release_busy", 32'(o_busy), 0);
        end
    endtask

    initial begin
        int writes;
        int swaps;
        done_v[0] = 1'b0; done_v[1] = 1'b0;
        trig_v[0] = 1'b0; trig_v[1] = 1'b0;

        // Reset state
        tick();
        chk("rst_swap", 32'(if1.swap), 0);
        chk("rst_we", 32'(if1.fb_we), 0);
        chk("rst_select", 32'(if1.select), 0);
        chk("rst_busy", 32'(if1.busy), 0);
        chk("rst_busy3", 32'(if3.busy), 0);
        resetn = 1'b1;

        // Idle with done low: frame edges must not start anything
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            trig_v[0] = (i % 2 == 0);
            tick();
            if (if1.fb_we || if1.busy || if1.swap) writes++;
        end
        trig_v[0] = 1'b0;
        chk("idle_activity", 32'(writes), 0);

        // Basic copy, latency 1
        sel = 0;
        start_copy(0);
        run_copy(0, 1, 1'b0, 3);

        // Latency 3
        sel = 1;
        start_copy(1);
        run_copy(1, 3, 1'b0, 3);
        sel = 0;

        // Aborted request
        done_v[0] = 1'b1;
        tick();
        tick();
        chk("abort_wait_busy", 32'(if1.busy), 1);
        done_v[0] = 1'b0;
        tick();
        chk("abort_idle_busy", 32'(if1.busy), 0);
        writes = 0;
        swaps = 0;
        for (int i = 0; i < 8; i++) begin
            trig_v[0] = (i % 2 == 0);
            tick();
            if (if1.fb_we) writes++;
            if (if1.swap) swaps++;
        end
        trig_v[0] = 1'b0;
        chk("abort_writes", 32'(writes), 0);
        chk("abort_swaps", 32'(swaps), 0);

        // Mid-copy trigger edge and done drop
        start_copy(0);
        run_copy(0, 1, 1'b1, 2);
        chk("disturb_idle_busy", 32'(if1.busy), 0);

        // Reset mid-copy
        start_copy(0);
        for (int cyc = 1; cyc <= 6; cyc++) tick();
        chk("midrst_pre_we", 32'(if1.fb_we), 1);
        chk("midrst_pre_waddr", 32'(if1.fb_waddr), 5);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_we", 32'(if1.fb_we), 0);
        chk("midrst_busy", 32'(if1.busy), 0);
        chk("midrst_select", 32'(if1.select), 0);
        done_v[0] = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        start_copy(0);
        run_copy(0, 1, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
